// File: rtl/rom_pkg.sv
// Shared mode encoding for the ROM address scanner and any display logic that
// decodes its mode output.
package rom_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    AUTO_UP   = 2'd0,
    AUTO_DOWN = 2'd1,
    HOLD      = 2'd2
  } mode_t;

  // Mode key cycles AUTO_UP -> AUTO_DOWN -> HOLD -> AUTO_UP.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      AUTO_UP:   next_mode = AUTO_DOWN;
      AUTO_DOWN: next_mode = HOLD;
      default:   next_mode = AUTO_UP;
    endcase
  endfunction

endpackage

// File: rtl/rom_dwell_timer.sv
// Dwell counter: counts 0..DWELL_CNT while enabled, flags the terminal count,
// and sits at zero while disabled or cleared.
module rom_dwell_timer #(
  parameter int DWELL_CNT = 9_999_999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CNT_W = (DWELL_CNT > 0) ? $clog2(DWELL_CNT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CNT);

  logic [CNT_W-1:0] cnt;

  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rom_scan_ctrl.sv
// ROM address scanner: auto up/down scan with a dwell timer, hold mode, and
// key-driven single steps with wrap at DEPTH-1.
module rom_scan_ctrl
  import rom_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int DWELL_CNT = 9_999_999
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              key_next_flag,
  input  logic              key_prev_flag,
  input  logic              key_mode_flag,
  output logic [ADDR_W-1:0] addr,
  output logic [MODE_W-1:0] mode,
  output logic              addr_vld
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  // addr_vld is a one-cycle strobe, high exactly in the cycle addr carries a
  // new value; there is no ready, consumers must sample it when it is high.
  mode_t state;
  logic  armed;
  logic  auto_mode;
  logic  mode_key;
  logic  next_key;
  logic  prev_key;
  logic  clr;
  logic  tc;

  assign mode = state;

  // Keys are masked in the first cycle after reset release via armed.
  always_comb begin
    auto_mode = (state == AUTO_UP) || (state == AUTO_DOWN);
    mode_key  = armed & key_mode_flag;
    next_key  = armed & key_next_flag & ~key_prev_flag;
    prev_key  = armed & key_prev_flag & ~key_next_flag;
    clr       = mode_key | (auto_mode & (next_key | prev_key));
  end

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    addr_inc = (a >= LAST) ? '0 : ADDR_W'(a + 1'b1);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_dec(input logic [ADDR_W-1:0] a);
    addr_dec = (a == '0) ? LAST : ADDR_W'(a - 1'b1);
  endfunction

  rom_dwell_timer #(
    .DWELL_CNT(DWELL_CNT)
  ) u_dwell (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .en   (auto_mode),
    .clr  (clr),
    .tc   (tc)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= AUTO_UP;
      addr     <= '0;
      addr_vld <= 1'b0;
      armed    <= 1'b0;
    end else begin
      armed    <= 1'b1;
      addr_vld <= 1'b0;
      if (!(auto_mode || (state == HOLD))) begin
        state <= AUTO_UP;
      end else if (mode_key) begin
        // Mode change wins over any step, including a coincident terminal count.
        state <= next_mode(state);
      end else if (next_key) begin
        addr     <= addr_inc(addr);
        addr_vld <= 1'b1;
      end else if (prev_key) begin
        addr     <= addr_dec(addr);
        addr_vld <= 1'b1;
      end else if (tc) begin
        addr     <= (state == AUTO_UP) ? addr_inc(addr) : addr_dec(addr);
        addr_vld <= 1'b1;
      end
    end
  end

endmodule
